// File: rtl/xgmii_frame_sequencer.sv
// Framed lane-stream generator: idle, start/preamble, counting payload,
// terminate and inter-packet gap, one NL-lane word per clock.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start, len    frame request and payload octet count (taken when ready=1)
//   ready         high while idle and able to accept a request
//   done          one-cycle pulse on the word that carries the terminate
//   len_err       one-cycle pulse when a request had len=0 or len>MAX_LEN
//   frame_count   completed frames, wraps at 2^32
//   data_out      lane j in data_out[j*8+:8]; lane 0 goes first on the wire
//   ctrl_out      bit j set when lane j holds a control character
module xgmii_frame_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_LEN    = 1518,
    parameter int IPG_WORDS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic                    ready,
    output logic                    done,
    output logic                    len_err,
    output logic [31:0]             frame_count,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH/8-1:0] ctrl_out
);

    localparam int NL = DATA_WIDTH / 8;
    localparam int CW = (IPG_WORDS > 0) ? $clog2(IPG_WORDS + 1) : 1;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] D_PRE   = 8'h55;
    localparam logic [7:0] D_SFD   = 8'hD5;

    localparam logic [DATA_WIDTH-1:0] IDLE_W  = {NL{C_IDLE}};
    localparam logic [DATA_WIDTH-1:0] START_W = {D_SFD, {(NL-2){D_PRE}}, C_START};
    localparam logic [NL-1:0]         START_C = {{(NL-1){1'b0}}, 1'b1};

    localparam logic [LEN_WIDTH-1:0] LEN_NL  = LEN_WIDTH'(NL);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);
    localparam logic [CW-1:0]        IPG_END = CW'(IPG_WORDS);

    // The state names the word currently presented on data_out/ctrl_out.
    // TERM covers both the full terminate word and a partial payload word
    // that carries the terminate character.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PAYLOAD,
        S_TERM,
        S_IPG
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] rem;
    logic [7:0]           idx;
    logic [CW-1:0]        ipg_cnt;

    logic                  len_ok;
    logic                  full_word;
    logic [DATA_WIDTH-1:0] pay_data;
    logic [NL-1:0]         pay_ctrl;

    assign len_ok    = (len != '0) && (len <= LEN_MAX);
    assign full_word = (rem >= LEN_NL);

    // Next payload word from the remaining octet count. When fewer than NL
    // octets remain, lane rem carries the terminate and the rest are idle;
    // rem == 0 therefore yields the plain terminate word.
    always_comb begin
        pay_data = IDLE_W;
        pay_ctrl = '1;
        for (int j = 0; j < NL; j++) begin
            if (LEN_WIDTH'(j) < rem) begin
                pay_data[j*8 +: 8] = idx + 8'(j);
                pay_ctrl[j]        = 1'b0;
            end else if (LEN_WIDTH'(j) == rem) begin
                pay_data[j*8 +: 8] = C_TERM;
                pay_ctrl[j]        = 1'b1;
            end else begin
                pay_data[j*8 +: 8] = C_IDLE;
                pay_ctrl[j]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rem         <= '0;
            idx         <= '0;
            ipg_cnt     <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            len_err     <= 1'b0;
            frame_count <= '0;
            data_out    <= IDLE_W;
            ctrl_out    <= '1;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    data_out <= IDLE_W;
                    ctrl_out <= '1;
                    if (start) begin
                        if (len_ok) begin
                            state    <= S_START;
                            ready    <= 1'b0;
                            rem      <= len;
                            idx      <= '0;
                            data_out <= START_W;
                            ctrl_out <= START_C;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end

                S_START, S_PAYLOAD: begin
                    data_out <= pay_data;
                    ctrl_out <= pay_ctrl;
                    if (full_word) begin
                        state <= S_PAYLOAD;
                        rem   <= rem - LEN_NL;
                        idx   <= idx + 8'(NL);
                    end else begin
                        state       <= S_TERM;
                        rem         <= '0;
                        done        <= 1'b1;
                        frame_count <= frame_count + 32'd1;
                    end
                end

                S_TERM: begin
                    data_out <= IDLE_W;
                    ctrl_out <= '1;
                    if (IPG_WORDS == 0) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        state   <= S_IPG;
                        ipg_cnt <= CW'(1);
                    end
                end

                S_IPG: begin
                    data_out <= IDLE_W;
                    ctrl_out <= '1;
                    if (ipg_cnt >= IPG_END) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        ipg_cnt <= ipg_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    ready    <= 1'b1;
                    data_out <= IDLE_W;
                    ctrl_out <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_frame_sequencer.sv
// Self-checking bench for xgmii_frame_sequencer: frames are modelled as an
// octet stream chopped into words and compared word by word.
module tb_xgmii_frame_sequencer;

    localparam int DW  = 64;
    localparam int LW  = 16;
    localparam int ML  = 1518;
    localparam int IPG = 2;
    localparam int NL  = DW / 8;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          ready;
    logic          done;
    logic          len_err;
    logic [31:0]   frame_count;
    logic [DW-1:0] data_out;
    logic [NL-1:0] ctrl_out;

    int n_chk = 0;
    int n_pass = 0;
    int fc = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        dn;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];

    xgmii_frame_sequencer #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .MAX_LEN   (ML),
        .IPG_WORDS (IPG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .ready      (ready),
        .done       (done),
        .len_err    (len_err),
        .frame_count(frame_count),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " data"}, data_out, IDLE_W);
        chk({tag, " ctrl"}, ctrl_out, 8'hFF);
        chk({tag, " ready"}, ready, 1'b1);
        chk({tag, " done"}, done, 1'b0);
    endtask

    // Octet-level model: preamble, counting payload, terminate, idle pad
    // to a word boundary, then the inter-packet gap words.
    task automatic build(input int l);
        logic [8:0] oq[$];
        word_t      w;
        int         nw;
        exp_q.delete();
        oq.push_back({1'b1, 8'hFB});
        for (int i = 0; i < NL - 2; i++) oq.push_back({1'b0, 8'h55});
        oq.push_back({1'b0, 8'hD5});
        for (int i = 0; i < l; i++) oq.push_back({1'b0, 8'(i % 256)});
        oq.push_back({1'b1, 8'hFD});
        while (oq.size() % NL != 0) oq.push_back({1'b1, 8'h07});
        nw = oq.size() / NL;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < NL; j++) begin
                w.d[j*8 +: 8] = oq[k*NL + j][7:0];
                w.c[j]        = oq[k*NL + j][8];
            end
            w.dn = (k == nw - 1);
            exp_q.push_back(w);
        end
        for (int i = 0; i < IPG; i++) begin
            w.d  = IDLE_W;
            w.c  = 8'hFF;
            w.dn = 1'b0;
            exp_q.push_back(w);
        end
    endtask

    // Requests one frame and checks every word through the gap. Without
    // hold, start toggles randomly while busy; len is garbage while busy.
    task automatic run_frame(input int l, input bit hold);
        word_t w;
        string t;
        build(l);
        got_q.delete();
        start = 1'b1;
        len   = LW'(l);
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            if (!hold) start = 1'($urandom);
            len = LW'($urandom);
            t = $sformatf("len%0d w%0d", l, k);
            chk({t, " data"}, data_out, exp_q[k].d);
            chk({t, " ctrl"}, ctrl_out, exp_q[k].c);
            chk({t, " done"}, done, exp_q[k].dn);
            chk({t, " ready"}, ready, 1'b0);
            w.d  = data_out;
            w.c  = ctrl_out;
            w.dn = done;
            got_q.push_back(w);
            tick();
        end
        fc++;
        if (!hold) start = 1'b0;
        len = LW'(l);
        chk_idle($sformatf("len%0d after", l));
        chk($sformatf("len%0d count", l), frame_count, 32'(fc));
    endtask

    task automatic bad_len(input int l);
        start = 1'b1;
        len   = LW'(l);
        tick();
        start = 1'b0;
        chk($sformatf("bad%0d len_err", l), len_err, 1'b1);
        chk_idle($sformatf("bad%0d", l));
        chk($sformatf("bad%0d count", l), frame_count, 32'(fc));
        tick();
        chk($sformatf("bad%0d len_err off", l), len_err, 1'b0);
        chk_idle($sformatf("bad%0d next", l));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        tick();
        chk_idle("in reset");
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk_idle("reset idle");
        chk("reset count", frame_count, 32'd0);
        chk("reset len_err", len_err, 1'b0);

        run_frame(5, 1'b0);
        chk("len5 start data", got_q[0].d, 64'hD5555555555555FB);
        chk("len5 start ctrl", got_q[0].c, 8'h01);
        chk("len5 term data", got_q[1].d, 64'h0707FD0403020100);
        chk("len5 term ctrl", got_q[1].c, 8'hE0);

        run_frame(8, 1'b0);
        chk("len8 pay data", got_q[1].d, 64'h0706050403020100);
        chk("len8 pay ctrl", got_q[1].c, 8'h00);
        chk("len8 term data", got_q[2].d, 64'h07070707070707FD);
        chk("len8 term ctrl", got_q[2].c, 8'hFF);

        bad_len(0);
        bad_len(ML + 1);
        bad_len(int'($urandom_range(65535, ML + 2)));

        run_frame(ML, 1'b0);
        chk("max words", got_q.size(), 64'(1 + 190 + IPG));
        chk("max last data", got_q[190].d, 64'h07FDEDECEBEAE9E8);
        chk("max last ctrl", got_q[190].c, 8'hC0);

        run_frame(16, 1'b1);
        run_frame(16, 1'b1);
        run_frame(16, 1'b0);

        run_frame(1, 1'b0);
        run_frame(NL - 1, 1'b0);
        run_frame(NL + 1, 1'b0);
        repeat (8) run_frame(int'($urandom_range(64, 1)), 1'b0);

        start = 1'b1;
        len   = LW'(100);
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk_idle("mid reset");
        chk("mid reset count", frame_count, 32'd0);
        chk("mid reset len_err", len_err, 1'b0);
        fc = 0;
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post reset");
        run_frame(5, 1'b0);
        chk("post reset term", got_q[1].d, 64'h0707FD0403020100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
